// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the IF/ID pipeline register slice.
package if_id_stage_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STALL   = 2'd1,
    FLUSHED = 2'd2
  } if_id_state_e;

  // sll $0,$0,0
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam int unsigned RS_HI = 25;
  localparam int unsigned RS_LO = 21;
  localparam int unsigned RT_HI = 20;
  localparam int unsigned RT_LO = 16;

endpackage

// File: rtl/if_id_stage_if.sv
// Fetch-to-decode bus of the IF/ID stage; master is the surrounding pipeline, slave is the stage.
interface if_id_stage_if #(
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      Instruction_in;
  logic [31:0]      PCPlus4_in;
  logic             ID_EX_MemRead;
  logic [4:0]       ID_EX_Rt;
  logic             Flush;
  logic [31:0]      Instruction_out;
  logic [31:0]      PCPlus4_out;
  logic             Valid_out;
  logic             PCWrite;
  logic             Bubble;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    output Instruction_in, PCPlus4_in, ID_EX_MemRead, ID_EX_Rt, Flush,
    input  Instruction_out, PCPlus4_out, Valid_out, PCWrite, Bubble,
           StallCount, FlushCount
  );

  modport slave (
    input  Instruction_in, PCPlus4_in, ID_EX_MemRead, ID_EX_Rt, Flush,
    output Instruction_out, PCPlus4_out, Valid_out, PCWrite, Bubble,
           StallCount, FlushCount
  );
endinterface

// File: rtl/if_id_stage_hazard_detect.sv
// Load-use hazard check of the latched IF/ID instruction against the load in ID/EX.
module hazard_detect (
  input  logic       valid,
  input  logic       mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       haz
);

  // rt is compared for every opcode; occasional false stalls on I-type are accepted
  always_comb begin
    haz = valid & mem_read & (ex_rt != 5'd0) & ((ex_rt == id_rs) | (ex_rt == id_rt));
  end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use stall, branch flush and debug event counters.
module if_id_stage #(
  parameter logic [31:0] NOP_WORD = if_id_stage_pkg::NOP_WORD,
  parameter int unsigned CNT_W    = 16
) (
  input logic          Clk,
  input logic          Reset,
  if_id_stage_if.slave bus
);
  import if_id_stage_pkg::*;

  if_id_state_e     state;
  logic [31:0]      instr_q;
  logic [31:0]      pc4_q;
  logic             valid_q;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             haz;
  logic             stall;

  hazard_detect u_hazard_detect (
    .valid    (valid_q),
    .mem_read (bus.ID_EX_MemRead),
    .ex_rt    (bus.ID_EX_Rt),
    .id_rs    (instr_q[RS_HI:RS_LO]),
    .id_rt    (instr_q[RT_HI:RT_LO]),
    .haz      (haz)
  );

  // Flush wins over a hazard; both enables are forced low while reset is held
  always_comb begin
    stall           = haz & ~bus.Flush;
    bus.PCWrite     = Reset & ~stall;
    bus.Bubble      = Reset & stall;
    bus.Instruction_out = instr_q;
    bus.PCPlus4_out = pc4_q;
    bus.Valid_out   = valid_q;
    bus.StallCount  = stall_cnt;
    bus.FlushCount  = flush_cnt;
  end

  // FSM and IF/ID registers: load, hold on stall, squash to NOP on flush
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= RUN;
      instr_q <= NOP_WORD;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (bus.Flush) begin
        state   <= FLUSHED;
        instr_q <= NOP_WORD;
        pc4_q   <= bus.PCPlus4_in;
        valid_q <= 1'b0;
      end else begin
        case (state)
          RUN, STALL: begin
            if (haz) begin
              state <= STALL;
            end else begin
              state   <= RUN;
              instr_q <= bus.Instruction_in;
              pc4_q   <= bus.PCPlus4_in;
              valid_q <= 1'b1;
            end
          end
          default: begin
            // squashed slot: Valid_out is low so no hazard can be raised here
            state   <= RUN;
            instr_q <= bus.Instruction_in;
            pc4_q   <= bus.PCPlus4_in;
            valid_q <= 1'b1;
          end
        endcase
      end
    end
  end

  // Saturating stall / flush event counters
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (bus.Flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage.
module tb_if_id_stage;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  int unsigned total = 0;
  int unsigned bad   = 0;

  if_id_stage_if #(.CNT_W(16)) bus ();

  if_id_stage #(.NOP_WORD(32'h0000_0000), .CNT_W(16)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance one edge and settle
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc4,
                       input logic mr, input logic [4:0] rt, input logic fl);
    bus.Instruction_in = ins;
    bus.PCPlus4_in     = pc4;
    bus.ID_EX_MemRead  = mr;
    bus.ID_EX_Rt       = rt;
    bus.Flush          = fl;
    #1;
  endtask

  initial begin
    // reset with random inputs
    drive($urandom, $urandom, 1'($urandom), 5'($urandom), 1'($urandom));
    repeat (3) tick();
    check("rst_instr", bus.Instruction_out, 32'h0);
    check("rst_pc4", bus.PCPlus4_out, 32'h0);
    check("rst_valid", 32'(bus.Valid_out), 32'h0);
    check("rst_pcwrite", 32'(bus.PCWrite), 32'h0);
    check("rst_bubble", 32'(bus.Bubble), 32'h0);
    check("rst_stallcnt", 32'(bus.StallCount), 32'h0);
    check("rst_flushcnt", 32'(bus.FlushCount), 32'h0);

    // first load after release
    drive(32'h2008_0005, 32'd4, 1'b0, 5'd0, 1'b0);
    Reset = 1'b1;
    tick();
    check("first_instr", bus.Instruction_out, 32'h2008_0005);
    check("first_pc4", bus.PCPlus4_out, 32'd4);
    check("first_valid", 32'(bus.Valid_out), 32'h1);

    // single load-use stall: add $t2,$t1,$t3 vs load into $t1
    drive(32'h012B_5020, 32'd8, 1'b0, 5'd0, 1'b0);
    tick();
    check("add_instr", bus.Instruction_out, 32'h012B_5020);
    drive(32'h8D0A_0000, 32'd12, 1'b1, 5'd9, 1'b0);
    check("haz_pcwrite", 32'(bus.PCWrite), 32'h0);
    check("haz_bubble", 32'(bus.Bubble), 32'h1);
    tick();
    check("stall_hold_instr", bus.Instruction_out, 32'h012B_5020);
    check("stall_hold_pc4", bus.PCPlus4_out, 32'd8);
    check("stall_hold_valid", 32'(bus.Valid_out), 32'h1);
    check("stall_cnt1", 32'(bus.StallCount), 32'd1);
    drive(32'h8D0A_0000, 32'd12, 1'b0, 5'd9, 1'b0);
    check("after_stall_pcwrite", 32'(bus.PCWrite), 32'h1);
    check("after_stall_bubble", 32'(bus.Bubble), 32'h0);
    tick();
    check("resume_instr", bus.Instruction_out, 32'h8D0A_0000);
    check("resume_pc4", bus.PCPlus4_out, 32'd12);

    // no stall when Rt is $zero or no load in EX
    drive(32'h012B_5020, 32'd16, 1'b0, 5'd0, 1'b0);
    tick();
    drive(32'h0100_0020, 32'd20, 1'b1, 5'd0, 1'b0);
    check("rt0_pcwrite", 32'(bus.PCWrite), 32'h1);
    check("rt0_bubble", 32'(bus.Bubble), 32'h0);
    drive(32'h0100_0020, 32'd20, 1'b0, 5'd9, 1'b0);
    check("nomr_pcwrite", 32'(bus.PCWrite), 32'h1);
    tick();
    check("nostall_instr", bus.Instruction_out, 32'h0100_0020);
    check("nostall_cnt", 32'(bus.StallCount), 32'd1);

    // flush together with a hazard (match on rt = $t3)
    drive(32'h012B_5020, 32'd24, 1'b0, 5'd0, 1'b0);
    tick();
    drive(32'hAAAA_5555, 32'd28, 1'b1, 5'd11, 1'b1);
    check("flush_pcwrite", 32'(bus.PCWrite), 32'h1);
    check("flush_bubble", 32'(bus.Bubble), 32'h0);
    tick();
    check("flush_instr", bus.Instruction_out, 32'h0);
    check("flush_valid", 32'(bus.Valid_out), 32'h0);
    check("flush_pc4", bus.PCPlus4_out, 32'd28);
    check("flush_cnt", 32'(bus.FlushCount), 32'd1);
    check("flush_stallcnt", 32'(bus.StallCount), 32'd1);
    drive(32'h012B_5020, 32'd32, 1'b1, 5'd0, 1'b0);
    check("flushed_pcwrite", 32'(bus.PCWrite), 32'h1);

    // back-to-back loads, then reset in the second stall cycle
    drive(32'h012B_5020, 32'd32, 1'b0, 5'd0, 1'b0);
    tick();
    check("b2b_valid", 32'(bus.Valid_out), 32'h1);
    drive(32'h0000_1111, 32'd36, 1'b1, 5'd9, 1'b0);
    tick();
    check("b2b_cnt", 32'(bus.StallCount), 32'd2);
    check("b2b_bubble2", 32'(bus.Bubble), 32'h1);
    check("b2b_hold", bus.Instruction_out, 32'h012B_5020);
    Reset = 1'b0;
    #1;
    check("midrst_instr", bus.Instruction_out, 32'h0);
    check("midrst_pc4", bus.PCPlus4_out, 32'h0);
    check("midrst_valid", 32'(bus.Valid_out), 32'h0);
    check("midrst_pcwrite", 32'(bus.PCWrite), 32'h0);
    check("midrst_bubble", 32'(bus.Bubble), 32'h0);
    check("midrst_stallcnt", 32'(bus.StallCount), 32'h0);
    check("midrst_flushcnt", 32'(bus.FlushCount), 32'h0);
    tick();
    drive(32'h2008_0005, 32'd4, 1'b0, 5'd0, 1'b0);
    Reset = 1'b1;
    tick();
    check("relrst_instr", bus.Instruction_out, 32'h2008_0005);
    check("relrst_valid", 32'(bus.Valid_out), 32'h1);

    // sustained hazard drives StallCount to saturation
    drive(32'h012B_5020, 32'd8, 1'b0, 5'd0, 1'b0);
    tick();
    drive(32'h0000_2222, 32'd12, 1'b1, 5'd9, 1'b0);
    repeat (65534) tick();
    check("sat_fffe", 32'(bus.StallCount), 32'h0000_FFFE);
    tick();
    check("sat_ffff", 32'(bus.StallCount), 32'h0000_FFFF);
    repeat (3) tick();
    check("sat_nowrap", 32'(bus.StallCount), 32'h0000_FFFF);
    check("sat_hold_instr", bus.Instruction_out, 32'h012B_5020);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
